// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Fetch stage feeding fetch_buffer. After reset the PC is assembled from a
// two-word reset vector stored at instruction-memory words 0 (high half) and
// 1 (low half). Once running, it reads one 16-bit word per cycle from a
// combinational-read instruction memory. It presents either:
//   - {instr, pc+1} for an ordinary instruction word, or
//   - {32'b0, imm} for the word that follows an LDM opcode.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   reset        asynchronous, active-low reset
//   stall        hold PC and state (hazard unit)
//   redirect     load redirect_pc at the next rising edge; squashes this fetch
//   redirect_pc  redirect target
//   imem_addr    instruction memory word address (combinational)
//   imem_data    instruction memory read data for imem_addr, same cycle
//   fetch_word   48-bit word for fetch_buffer
//   fetch_valid  fetch_word carries a real, non-squashed fetch
//   imm_cycle    fetch_word[15:0] is an LDM immediate
//   pc           current PC
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int         ADDR_W     = 20,      // must not exceed 32
    parameter logic [4:0] LDM_OPCODE = 5'b11000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_data,
    output logic [47:0]       fetch_word,
    output logic              fetch_valid,
    output logic              imm_cycle,
    output logic [31:0]       pc
);

    typedef enum logic [1:0] {
        VEC_HI,   // reading reset vector high half
        VEC_LO,   // reading reset vector low half
        RUN,      // fetching instruction words
        IMM       // fetching the immediate that follows an LDM
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] pc_plus1;

    // 32-bit modulo increment: all-ones wraps to zero.
    assign pc_plus1 = pc_reg + 32'd1;
    assign pc       = pc_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= VEC_HI;
            pc_reg    <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        imem_addr   = pc_reg[ADDR_W-1:0];
        fetch_word  = '0;
        fetch_valid = 1'b0;
        imm_cycle   = 1'b0;

        case (state_reg)
            VEC_HI: begin
                // Vector load ignores stall and redirect; nothing is in flight yet.
                imem_addr  = '0;
                pc_next    = {imem_data, pc_reg[15:0]};
                state_next = VEC_LO;
            end

            VEC_LO: begin
                imem_addr  = ADDR_W'(1);
                pc_next    = {pc_reg[31:16], imem_data};
                state_next = RUN;
            end

            RUN: begin
                fetch_word  = {imem_data, pc_plus1};
                // Squash combinationally so a wrong-path word never reaches the buffer.
                fetch_valid = !redirect;
                if (redirect) begin
                    pc_next    = redirect_pc;
                    state_next = RUN;
                end else if (!stall) begin
                    pc_next = pc_plus1;
                    if (imem_data[15:11] == LDM_OPCODE) begin
                        state_next = IMM;
                    end
                end
            end

            IMM: begin
                fetch_word  = {32'b0, imem_data};
                fetch_valid = !redirect;
                imm_cycle   = !redirect;
                // The immediate is data: its opcode bits are never decoded, so a
                // completed IMM always returns to RUN. Redirect drops a pending IMM.
                if (redirect) begin
                    pc_next    = redirect_pc;
                    state_next = RUN;
                end else if (!stall) begin
                    pc_next    = pc_plus1;
                    state_next = RUN;
                end
            end

            default: begin
                state_next = VEC_HI;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Bench for fetch_unit. A 4096-word memory (aliased on the low 12 address
// bits) stands in for instruction memory. A reference model tracks the PC,
// how many vector halves remain to load, and whether the next word is an
// immediate. A compare process checks every DUT output against the model on
// each falling edge. Directed scenarios also pin literal expectations, and a
// randomized phase follows.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [19:0] imem_addr;
    logic [15:0] imem_data;
    logic [47:0] fetch_word;
    logic        fetch_valid;
    logic        imm_cycle;
    logic [31:0] pc;

    logic [15:0] mem [4096];

    int tests  = 0;
    int failed = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[11:0]];

    fetch_unit #(.ADDR_W(20), .LDM_OPCODE(5'b11000)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .fetch_word  (fetch_word),
        .fetch_valid (fetch_valid),
        .imm_cycle   (imm_cycle),
        .pc          (pc)
    );

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand_word();
        if ($urandom_range(0, 3) == 0) return {5'b11000, 11'($urandom)};
        return 16'($urandom);
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] m_pc;
    int          m_vec_left;   // vector halves still to load (2, 1, 0)
    bit          m_imm;        // next fetched word is an LDM immediate

    function automatic logic [19:0] model_addr();
        if (m_vec_left == 2) return 20'd0;
        if (m_vec_left == 1) return 20'd1;
        return m_pc[19:0];
    endfunction

    initial begin
        logic [19:0] e_addr;
        logic [15:0] d;
        logic [47:0] e_word;
        logic        e_valid, e_imm;
        m_pc = '0; m_vec_left = 2; m_imm = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                m_pc = '0; m_vec_left = 2; m_imm = 1'b0;
            end
            if (chk_en) begin
                e_addr = model_addr();
                d      = mem[e_addr[11:0]];
                if (m_vec_left != 0) begin
                    e_word = '0; e_valid = 1'b0; e_imm = 1'b0;
                end else if (m_imm) begin
                    e_word = {32'h0, d}; e_valid = !redirect; e_imm = !redirect;
                end else begin
                    e_word = {d, m_pc + 32'd1}; e_valid = !redirect; e_imm = 1'b0;
                end
                check("model_addr",  {28'h0, imem_addr}, {28'h0, e_addr});
                check("model_word",  fetch_word, e_word);
                check("model_valid", {47'h0, fetch_valid}, {47'h0, e_valid});
                check("model_imm",   {47'h0, imm_cycle}, {47'h0, e_imm});
                check("model_pc",    {16'h0, pc}, {16'h0, m_pc});
            end
            @(posedge clk);
            if (!reset) begin
                m_pc = '0; m_vec_left = 2; m_imm = 1'b0;
            end else begin
                e_addr = model_addr();
                d      = mem[e_addr[11:0]];
                if (m_vec_left == 2) begin
                    m_pc[31:16] = d; m_vec_left = 1;
                end else if (m_vec_left == 1) begin
                    m_pc[15:0] = d; m_vec_left = 0;
                end else if (redirect) begin
                    m_pc = redirect_pc; m_imm = 1'b0;
                end else if (stall) begin
                    // hold
                end else if (m_imm) begin
                    m_pc = m_pc + 32'd1; m_imm = 1'b0;
                end else begin
                    m_pc  = m_pc + 32'd1;
                    m_imm = (d[15:11] == 5'b11000);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = rand_word();
        mem[0]      = 16'h0000;
        mem[1]      = 16'h0010;
        mem[16]     = 16'h1234;
        mem[12'h20] = 16'hC123;
        mem[12'h21] = 16'hBEEF;
        mem[12'h22] = 16'h0001;
        mem[12'h30] = 16'h2222;
        mem[12'h40] = 16'hC000;
        mem[12'h41] = 16'hC7FF;   // immediate whose top bits look like LDM
        mem[12'h42] = 16'h0042;
        mem[12'h100] = 16'h0100;
        mem[12'hFFF] = 16'h1111;

        step(); step();
        chk_en = 1'b1;

        // T1: vector load after reset release
        reset = 1'b1; #2;
        check("t1_valid_hi", {47'h0, fetch_valid}, 48'h0);
        check("t1_addr_hi",  {28'h0, imem_addr}, 48'h0);
        check("t1_word_hi",  fetch_word, 48'h0);
        step(); #2;
        check("t1_valid_lo", {47'h0, fetch_valid}, 48'h0);
        check("t1_addr_lo",  {28'h0, imem_addr}, 48'h1);
        step(); #2;
        check("t1_pc",    {16'h0, pc}, 48'h10);
        check("t1_word",  fetch_word, 48'h1234_0000_0011);
        check("t1_valid", {47'h0, fetch_valid}, 48'h1);
        $display("[TB] T1 vector load: pc=%h word=%h", pc, fetch_word);

        // T2: LDM followed by immediate
        redirect = 1'b1; redirect_pc = 32'h20; #2;
        check("t2_squash", {47'h0, fetch_valid}, 48'h0);
        step(); redirect = 1'b0; #2;
        check("t2_c1_pc",   {16'h0, pc}, 48'h20);
        check("t2_c1_word", fetch_word, 48'hC123_0000_0021);
        step(); #2;
        check("t2_c2_imm",  {47'h0, imm_cycle}, 48'h1);
        check("t2_c2_word", fetch_word, 48'h0000_0000_BEEF);
        step(); #2;
        check("t2_c3_pc",  {16'h0, pc}, 48'h22);
        check("t2_c3_imm", {47'h0, imm_cycle}, 48'h0);
        $display("[TB] T2 LDM pair: pc=%h", pc);

        // T3: three-cycle stall
        redirect = 1'b1; redirect_pc = 32'h30;
        step(); redirect = 1'b0; stall = 1'b1; #2;
        check("t3_pc0",   {16'h0, pc}, 48'h30);
        check("t3_word0", fetch_word, 48'h2222_0000_0031);
        repeat (2) begin
            step(); #2;
            check("t3_pc_hold",   {16'h0, pc}, 48'h30);
            check("t3_word_hold", fetch_word, 48'h2222_0000_0031);
        end
        step(); stall = 1'b0; #2;
        check("t3_pc_last", {16'h0, pc}, 48'h30);
        step(); #2;
        check("t3_pc_after", {16'h0, pc}, 48'h31);
        $display("[TB] T3 stall: pc=%h", pc);

        // T4a: immediate with LDM-like bits is not decoded
        redirect = 1'b1; redirect_pc = 32'h40;
        step(); redirect = 1'b0; #2;
        check("t4a_word", fetch_word, 48'hC000_0000_0041);
        step(); #2;
        check("t4a_imm",      {47'h0, imm_cycle}, 48'h1);
        check("t4a_imm_word", fetch_word, 48'h0000_0000_C7FF);
        step(); #2;
        check("t4a_pc",   {16'h0, pc}, 48'h42);
        check("t4a_run",  {47'h0, imm_cycle}, 48'h0);
        check("t4a_word2", fetch_word, 48'h0042_0000_0043);

        // T4b: redirect beats stall and a pending immediate
        redirect = 1'b1; redirect_pc = 32'h40;
        step(); redirect = 1'b0;
        step();
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h100; #2;
        check("t4b_valid", {47'h0, fetch_valid}, 48'h0);
        check("t4b_imm",   {47'h0, imm_cycle}, 48'h0);
        step(); stall = 1'b0; redirect = 1'b0; #2;
        check("t4b_pc",    {16'h0, pc}, 48'h100);
        check("t4b_imm2",  {47'h0, imm_cycle}, 48'h0);
        check("t4b_word",  fetch_word, 48'h0100_0000_0101);
        $display("[TB] T4 redirect over stall/IMM: pc=%h", pc);

        // T5: PC wrap
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        step(); redirect = 1'b0; #2;
        check("t5_pc",     {16'h0, pc}, 48'hFFFF_FFFF);
        check("t5_addr",   {28'h0, imem_addr}, 48'hF_FFFF);
        check("t5_word_lo", {16'h0, fetch_word[31:0]}, 48'h0);
        step(); #2;
        check("t5_pc_wrap", {16'h0, pc}, 48'h0);
        $display("[TB] T5 wrap: pc=%h", pc);

        // T6: reset while in IMM
        redirect = 1'b1; redirect_pc = 32'h40;
        step(); redirect = 1'b0;
        step(); #2;
        check("t6_in_imm", {47'h0, imm_cycle}, 48'h1);
        reset = 1'b0; #2;
        check("t6_valid", {47'h0, fetch_valid}, 48'h0);
        check("t6_pc",    {16'h0, pc}, 48'h0);
        check("t6_imm",   {47'h0, imm_cycle}, 48'h0);
        step(); reset = 1'b1; #2;
        check("t6_addr_hi", {28'h0, imem_addr}, 48'h0);
        step(); #2;
        check("t6_addr_lo", {28'h0, imem_addr}, 48'h1);
        step(); #2;
        check("t6_pc_vec", {16'h0, pc}, 48'h10);
        $display("[TB] T6 reset in IMM: pc=%h", pc);

        // Randomized phase, checked by the model every cycle
        for (int n = 0; n < 3000; n++) begin
            step();
            reset       = ($urandom_range(0, 99) != 0);
            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 9) == 0);
            redirect_pc = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255));
        end
        step();
        reset = 1'b1; stall = 1'b0; redirect = 1'b0;
        step();
        $display("[TB] random phase done");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
